// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, instruction-memory handshake and IF/ID register.       |
// | Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_stage #(
   parameter int                 PC_W      = 10,
   parameter int                 INSTR_W   = 10,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hazard,
   input  logic               PC_hazard,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               halt,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] instr_ID,
   output logic [PC_W-1:0]    pc_ID,
   output logic               valid_ID,
   output logic [2:0]         rd_sel1_IF,
   output logic [2:0]         rd_sel2_IF,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_id_q, pc_id_d;
   logic               valid_q, valid_d;
   logic               stall;
   logic               accept;
   logic [PC_W-1:0]    pc_inc;

   assign stall  = hazard | PC_hazard;
   assign accept = imem_req & imem_valid;
   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc_id_d = pc_id_q;
      valid_d = valid_q;
      if (branch_taken) begin
         pc_d    = branch_target;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = S_FETCH;
      end else if (stall) begin
         // Everything holds; the same address is presented again next cycle.
      end else if (halt || state_q == S_HALTED) begin
         state_d = S_HALTED;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (accept) begin
         instr_d = imem_rdata;
         pc_id_d = pc_inc;
         valid_d = 1'b1;
         pc_d    = pc_inc;
         state_d = S_FETCH;
      end else begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = S_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc_id_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc_id_q <= pc_id_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr  = pc_q;
   assign imem_req   = (state_q != S_HALTED);
   assign halted     = (state_q == S_HALTED);
   assign instr_ID   = instr_q;
   assign pc_ID      = pc_id_q;
   assign valid_ID   = valid_q;
   assign rd_sel1_IF = instr_q[5:3];
   assign rd_sel2_IF = instr_q[2:0];

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && !branch_taken && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (branch_taken && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : self-checking bench for fetch_stage with a scoreboard   |
// | of expected {instr_ID, pc_ID} pairs. Revision 1.0                        |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hazard = 1'b0;
   logic       PC_hazard = 1'b0;
   logic       branch_taken = 1'b0;
   logic [9:0] branch_target = '0;
   logic       halt = 1'b0;
   logic [9:0] imem_addr;
   logic       imem_req;
   logic [9:0] imem_rdata = '0;
   logic       imem_valid = 1'b0;
   logic [9:0] instr_ID;
   logic [9:0] pc_ID;
   logic       valid_ID;
   logic [2:0] rd_sel1_IF;
   logic [2:0] rd_sel2_IF;
   logic       halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [19:0] exp_q[$];
   logic [19:0] e;
   logic [9:0]  last_instr;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .hazard(hazard), .PC_hazard(PC_hazard),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .instr_ID(instr_ID), .pc_ID(pc_ID),
      .valid_ID(valid_ID), .rd_sel1_IF(rd_sel1_IF), .rd_sel2_IF(rd_sel2_IF),
      .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++; if (imem_addr !== 10'h000) $display("FAIL reset_addr got %h want 000", imem_addr); else n_pass++;
      n_checks++; if (imem_req !== 1'b1) $display("FAIL reset_req got %b want 1", imem_req); else n_pass++;
      n_checks++; if ({valid_ID, instr_ID, pc_ID} !== 21'd0) $display("FAIL reset_ifid got %b/%h/%h want 0/000/000", valid_ID, instr_ID, pc_ID); else n_pass++;
      n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); else n_pass++;
`endif
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] data [5] = '{10'h0A5, 10'h1C3, 10'h102, 10'h103, 10'h104};
      imem_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         imem_rdata = data[i];
         exp_q.push_back({data[i], 10'(i + 1)});
         step();
         n_checks++;
         if (valid_ID !== 1'b1 || exp_q.size() == 0) $display("FAIL b2b_valid[%0d] got %b want 1", i, valid_ID);
         else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++; if ({instr_ID, pc_ID} !== e) $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, instr_ID, pc_ID, e[19:10], e[9:0]); else n_pass++;
         end
         if (i == 0) begin
            n_checks++; if ({rd_sel1_IF, rd_sel2_IF} !== 6'o45) $display("FAIL rd_sel got %0d/%0d want 4/5", rd_sel1_IF, rd_sel2_IF); else n_pass++;
         end
      end
      last_instr = 10'h104;
   endtask

   task automatic test_stall();
      hazard = 1'b1; PC_hazard = 1'b1; imem_rdata = 10'h3EE;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (imem_addr !== 10'h005) $display("FAIL stall_addr[%0d] got %h want 005", i, imem_addr); else n_pass++;
         n_checks++; if ({valid_ID, instr_ID, pc_ID} !== {1'b1, last_instr, 10'h005}) $display("FAIL stall_hold[%0d] got %b/%h/%h want 1/%h/005", i, valid_ID, instr_ID, pc_ID, last_instr); else n_pass++;
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if (stall_cnt !== 16'd2) $display("FAIL stall_cnt got %0d want 2", stall_cnt); else n_pass++;
`endif
      hazard = 1'b0; PC_hazard = 1'b0;
      for (int i = 5; i < 7; i++) begin
         imem_rdata = 10'h200 + 10'(i);
         exp_q.push_back({10'h200 + 10'(i), 10'(i + 1)});
         step();
         e = exp_q.pop_front();
         n_checks++; if ({valid_ID, instr_ID, pc_ID} !== {1'b1, e}) $display("FAIL stall_resume[%0d] got %b/%h/%h want 1/%h/%h", i, valid_ID, instr_ID, pc_ID, e[19:10], e[9:0]); else n_pass++;
      end
   endtask

   task automatic test_wait();
      imem_valid = 1'b0; imem_rdata = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (valid_ID !== 1'b0) $display("FAIL wait_valid[%0d] got %b want 0", i, valid_ID); else n_pass++;
         n_checks++; if (imem_addr !== 10'h007 || imem_req !== 1'b1) $display("FAIL wait_addr[%0d] got %h/%b want 007/1", i, imem_addr, imem_req); else n_pass++;
      end
      imem_valid = 1'b1; imem_rdata = 10'h2D7;
      exp_q.push_back({10'h2D7, 10'h008});
      step();
      e = exp_q.pop_front();
      n_checks++; if ({valid_ID, instr_ID, pc_ID} !== {1'b1, e}) $display("FAIL wait_load got %b/%h/%h want 1/%h/%h", valid_ID, instr_ID, pc_ID, e[19:10], e[9:0]); else n_pass++;
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_target = 10'h120; hazard = 1'b1; imem_rdata = 10'h155;
      step();
      branch_taken = 1'b0; hazard = 1'b0;
      n_checks++; if ({valid_ID, instr_ID} !== 11'd0) $display("FAIL branch_bubble got %b/%h want 0/000", valid_ID, instr_ID); else n_pass++;
      n_checks++; if (imem_addr !== 10'h120) $display("FAIL branch_addr got %h want 120", imem_addr); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) $display("FAIL branch_cnt got %0d/%0d want 1/2", flush_cnt, stall_cnt); else n_pass++;
`endif
   endtask

   task automatic test_halt();
      halt = 1'b1; imem_rdata = 10'h0F0;
      step();
      halt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++; if ({halted, imem_req, valid_ID} !== 3'b100) $display("FAIL halt_state[%0d] got %b%b%b want 100", i, halted, imem_req, valid_ID); else n_pass++;
         n_checks++; if (imem_addr !== 10'h120) $display("FAIL halt_addr[%0d] got %h want 120", i, imem_addr); else n_pass++;
         step();
      end
      branch_taken = 1'b1; branch_target = 10'h040;
      step();
      branch_taken = 1'b0;
      n_checks++; if ({halted, imem_req, valid_ID} !== 3'b010 || imem_addr !== 10'h040) $display("FAIL halt_exit got %b%b%b/%h want 010/040", halted, imem_req, valid_ID, imem_addr); else n_pass++;
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1; branch_target = 10'h3FF;
      step();
      branch_taken = 1'b0; imem_rdata = 10'h2AB;
      exp_q.push_back({10'h2AB, 10'h000});
      step();
      e = exp_q.pop_front();
      n_checks++; if ({valid_ID, instr_ID, pc_ID} !== {1'b1, e}) $display("FAIL wrap_load got %b/%h/%h want 1/%h/%h", valid_ID, instr_ID, pc_ID, e[19:10], e[9:0]); else n_pass++;
      n_checks++; if (imem_addr !== 10'h000) $display("FAIL wrap_addr got %h want 000", imem_addr); else n_pass++;
   endtask

   task automatic test_reset_mid();
      imem_valid = 1'b0;
      step();
      step();
      hazard = 1'b1; reset = 1'b1;
      step();
      n_checks++; if ({valid_ID, instr_ID, pc_ID, imem_addr} !== 31'd0 || halted !== 1'b0 || imem_req !== 1'b1) $display("FAIL reset_mid got %b/%h/%h/%h want 0/000/000/000", valid_ID, instr_ID, pc_ID, imem_addr); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL reset_mid_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); else n_pass++;
`endif
      reset = 1'b0; hazard = 1'b0;
      n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_wait();
      test_branch();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
